// File: rtl/nibble_serial_add_sub_if.sv
// Handshake/data bundle for nibble_serial_add_sub.
//   in_valid/in_ready : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (result, cout, ovf)
//   busy : block is computing or holding a result
// master = operand producer / result consumer; slave = the adder.
interface nibble_serial_add_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_add_sub.sv
// Nibble-serial WIDTH-bit adder/subtractor. Operands are captured on an
// in_valid/in_ready handshake, then one 4-bit nibble per clock is added
// (LSB first) with the carry held between cycles. Result, carry and signed
// overflow are presented on an out_valid/out_ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : nibble_serial_add_sub_if slave modport (handshakes, operands,
//          result, flags, busy)
module nibble_serial_add_sub #(
  parameter int unsigned WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  nibble_serial_add_sub_if.slave   bus
);
  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;      // B, already inverted for subtract
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  // 4-bit slice: nibble of A + nibble of inverted B + carry.
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] slice_sum;

  always_comb begin
    a_nib     = a_q[4*idx_q +: 4];
    b_nib     = bx_q[4*idx_q +: 4];
    slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      bx_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready is simply "idle and not in reset" here.
          if (bus.in_valid) begin
            a_q      <= bus.a;
            bx_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q  <= bus.sub;   // +1 completes the two's complement
            idx_q    <= '0;
            result_q <= '0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          result_q[4*idx_q +: 4] <= slice_sum[3:0];
          carry_q                <= slice_sum[4];
          if (idx_q == LastIdx) begin
            cout_q      <= slice_sum[4];
            // Operands of like sign producing a result of the other sign.
            ovf_q       <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) &
                           (slice_sum[3] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_sub.sv
module tb_nibble_serial_add_sub;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  nibble_serial_add_sub_if #(.WIDTH(16)) bus16 ();
  nibble_serial_add_sub_if #(.WIDTH(8))  bus8 ();

  nibble_serial_add_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  nibble_serial_add_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] r, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur > 65535);
      sr = sa + sb;
    end
    r = ur[15:0];
    o = (sr > 32767) || (sr < -32768);
  endtask

  // Called #1 after a posedge with the block idle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    bus16.a        = a;
    bus16.b        = b;
    bus16.sub      = sub;
    bus16.in_valid = 1'b1;
    check("in_ready_idle", 32'(bus16.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid; checks latency and in_ready.
  task automatic wait_done(input int exp_lat);
    int  edges;
    bit  seen;
    bit  rdy_bad;
    edges   = 0;
    seen    = 0;
    rdy_bad = 0;
    while (!seen && edges < 20) begin
      if (bus16.in_ready !== 1'b0) rdy_bad = 1;
      @(posedge clk);
      #1;
      edges++;
      if (bus16.out_valid === 1'b1) seen = 1;
    end
    check("out_valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("in_ready_low_busy", 32'(rdy_bad), 32'd0);
  endtask

  task automatic check_out(input string name, input logic [15:0] res, input logic c,
                           input logic o);
    check({name, "_result"}, 32'(bus16.result), 32'(res));
    check({name, "_cout"}, 32'(bus16.cout), 32'(c));
    check({name, "_ovf"}, 32'(bus16.ovf), 32'(o));
  endtask

  task automatic drain();
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    check("drain_out_valid", 32'(bus16.out_valid), 32'd0);
    check("drain_in_ready", 32'(bus16.in_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [15:0] r;
    logic        c;
    logic        o;
    logic [15:0] ra, rb;
    logic        rs;
    int          edges;

    tests  = 0;
    failed = 0;

    vecs[0] = '{a: 16'h1234, b: 16'h0FFF, sub: 1'b0, res: 16'h2233, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, res: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 16'h0007, b: 16'h0005, sub: 1'b1, res: 16'h0002, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, res: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, res: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, res: 16'h0000, cout: 1'b1, ovf: 1'b0};

    bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.sub = 0; bus16.out_ready = 0;
    bus8.in_valid  = 0; bus8.a  = '0; bus8.b  = '0; bus8.sub  = 0; bus8.out_ready  = 0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus16.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_result", 32'(bus16.result), 32'd0);
    check("rst_flags", {30'd0, bus16.cout, bus16.ovf}, 32'd0);
    check("rst_busy", 32'(bus16.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(bus16.in_ready), 32'd1);

    // Directed table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(4);
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].cout, vecs[i].ovf);
      drain();
    end

    // Backpressure: result held while new operands wait on in_valid
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_done(4);
    bus16.a        = 16'h0100;
    bus16.b        = 16'h0003;
    bus16.sub      = 1'b1;
    bus16.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(bus16.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus16.in_ready), 32'd0);
      check_out("bp_hold", 16'h2233, 1'b0, 1'b0);
    end
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    check("bp_handshake_valid", 32'(bus16.out_valid), 32'd0);
    check("bp_handshake_busy", 32'(bus16.busy), 32'd0);
    start_op(16'h0100, 16'h0003, 1'b1);
    wait_done(4);
    check_out("bp_new", 16'h00FD, 1'b1, 1'b0);
    drain();

    // Reset abort after 2 CALC edges
    start_op(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus16.out_valid), 32'd0);
    check("abort_result", 32'(bus16.result), 32'd0);
    check("abort_busy", 32'(bus16.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus16.in_ready), 32'd1);
    @(posedge clk);
    #1;
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done(4);
    check_out("after_abort", 16'h0100, 1'b0, 1'b0);
    drain();

    // Randomized against the reference model
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (k % 8 == 0) rb = ra;  // equal operands exercise the A==B borrow edge
      model(ra, rb, rs, r, c, o);
      start_op(ra, rb, rs);
      wait_done(4);
      check_out($sformatf("rnd%0d_%h_%h_%0d", k, ra, rb, rs), r, c, o);
      drain();
    end

    // WIDTH=8 instance: 0x7F + 0x01
    check("w8_in_ready", 32'(bus8.in_ready), 32'd1);
    bus8.a        = 8'h7F;
    bus8.b        = 8'h01;
    bus8.sub      = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    edges = 0;
    while (bus8.out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("w8_latency", 32'(edges), 32'd2);
    check("w8_result", 32'(bus8.result), 32'h80);
    check("w8_cout", 32'(bus8.cout), 32'd0);
    check("w8_ovf", 32'(bus8.ovf), 32'd1);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    check("w8_drain", 32'(bus8.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
